// File: rtl/fetch_queue.sv
// Sequential instruction fetch front-end: credit-limited request issue, in-order
// response capture into a small {inst, pc} FIFO, and redirect with in-flight drop.
`timescale 1ns/1ps

module fetch_queue #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned DEPTH    = 2
) (
   input  logic        clk_i,
   input  logic        rst_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_gnt_i,
   input  logic        imem_rvalid_i,
   input  logic [31:0] imem_rdata_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic        inst_valid_o,
   output logic [31:0] inst_o,
   output logic [31:0] inst_pc_o,
   input  logic        inst_ready_i
);

   localparam int unsigned AW          = $clog2(DEPTH);
   localparam int unsigned CW          = $clog2(DEPTH + 1);
   localparam logic [CW:0] DEPTH_C     = (CW + 1)'(DEPTH);
   localparam logic [31:0] RESET_PC_AL = {RESET_PC[31:2], 2'b00};

   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic [31:0]   resp_pc_q, resp_pc_d;
   logic [CW-1:0] count_q, count_d;
   logic [CW-1:0] pend_q, pend_d;
   logic [CW-1:0] drop_q, drop_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [31:0]   inst_mem_q [DEPTH];
   logic [31:0]   inst_mem_d [DEPTH];
   logic [31:0]   pc_mem_q   [DEPTH];
   logic [31:0]   pc_mem_d   [DEPTH];

   logic [CW:0]   credit_used;
   logic [31:0]   redirect_tgt;
   logic          grant;
   logic          rsp_ok;
   logic          push;
   logic          pop;
   logic          unused_pc_lsb;

   always_comb begin
      credit_used   = {1'b0, count_q} + {1'b0, pend_q};
      redirect_tgt  = {redirect_pc_i[31:2], 2'b00};
      unused_pc_lsb = ^redirect_pc_i[1:0];
      // Requests are held off during reset and in a redirect cycle; the
      // credit check reserves a FIFO slot for every outstanding request.
      imem_req_o    = !rst_i && !redirect_i && (credit_used < DEPTH_C);
      imem_addr_o   = fetch_pc_q;
      grant         = imem_req_o && imem_gnt_i;
      rsp_ok        = imem_rvalid_i && (pend_q != '0);
      push          = rsp_ok && (drop_q == '0) && !redirect_i;
      pop           = (count_q != '0) && inst_ready_i && !redirect_i;
   end

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      resp_pc_d  = resp_pc_q;
      pend_d     = pend_q;
      drop_d     = drop_q;
      count_d    = count_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      inst_mem_d = inst_mem_q;
      pc_mem_d   = pc_mem_q;

      unique case ({grant, rsp_ok})
         2'b10:   pend_d = pend_q + CW'(1);
         2'b01:   pend_d = pend_q - CW'(1);
         default: pend_d = pend_q;
      endcase

      if (grant) begin
         fetch_pc_d = fetch_pc_q + 32'd4;
      end

      if (push) begin
         inst_mem_d[wr_ptr_q] = imem_rdata_i;
         pc_mem_d[wr_ptr_q]   = resp_pc_q;
         wr_ptr_d             = wr_ptr_q + AW'(1);
         resp_pc_d            = resp_pc_q + 32'd4;
      end

      if (pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end

      unique case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase

      if (rsp_ok && (drop_q != '0)) begin
         drop_d = drop_q - CW'(1);
      end

      // Every request still in flight after this cycle's response becomes
      // stale; pend keeps its normal update so the drop count stays <= pend.
      if (redirect_i) begin
         fetch_pc_d = redirect_tgt;
         resp_pc_d  = redirect_tgt;
         drop_d     = pend_q - CW'(rsp_ok);
         count_d    = '0;
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         fetch_pc_q <= RESET_PC_AL;
         resp_pc_q  <= RESET_PC_AL;
         count_q    <= '0;
         pend_q     <= '0;
         drop_q     <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         inst_mem_q <= '{default: '0};
         pc_mem_q   <= '{default: '0};
      end else begin
         fetch_pc_q <= fetch_pc_d;
         resp_pc_q  <= resp_pc_d;
         count_q    <= count_d;
         pend_q     <= pend_d;
         drop_q     <= drop_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         inst_mem_q <= inst_mem_d;
         pc_mem_q   <= pc_mem_d;
      end
   end

   always_comb begin
      inst_valid_o = (count_q != '0);
      inst_o       = inst_mem_q[rd_ptr_q];
      inst_pc_o    = pc_mem_q[rd_ptr_q];
   end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: DEPTH=2 instance driven from a vector table,
// DEPTH=4 instance for streaming, simultaneous events, redirects and async reset.
`timescale 1ns/1ps

module tb_fetch_queue;

   localparam logic [31:0] A = 32'hA500_0000;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_a, req_a, gnt_a, rv_a, redir_a, valid_a, ready_a;
   logic [31:0] addr_a, rdata_a, rpc_a, inst_a, pc_a;
   logic        rst_b, req_b, gnt_b, rv_b, redir_b, valid_b, ready_b;
   logic [31:0] addr_b, rdata_b, rpc_b, inst_b, pc_b;

   fetch_queue #(.RESET_PC(32'h0000_0000), .DEPTH(2)) u_dut_a (
      .clk_i(clk), .rst_i(rst_a),
      .imem_req_o(req_a), .imem_addr_o(addr_a), .imem_gnt_i(gnt_a),
      .imem_rvalid_i(rv_a), .imem_rdata_i(rdata_a),
      .redirect_i(redir_a), .redirect_pc_i(rpc_a),
      .inst_valid_o(valid_a), .inst_o(inst_a), .inst_pc_o(pc_a),
      .inst_ready_i(ready_a)
   );

   fetch_queue #(.RESET_PC(32'h0000_0200), .DEPTH(4)) u_dut_b (
      .clk_i(clk), .rst_i(rst_b),
      .imem_req_o(req_b), .imem_addr_o(addr_b), .imem_gnt_i(gnt_b),
      .imem_rvalid_i(rv_b), .imem_rdata_i(rdata_b),
      .redirect_i(redir_b), .redirect_pc_i(rpc_b),
      .inst_valid_o(valid_b), .inst_o(inst_b), .inst_pc_o(pc_b),
      .inst_ready_i(ready_b)
   );

   typedef struct {
      logic        rst;
      logic        gnt;
      logic        rv;
      logic [31:0] rdata;
      logic        redir;
      logic [31:0] rpc;
      logic        ready;
      logic        req;
      logic [31:0] addr;
      logic        valid;
      logic [31:0] inst;
      logic [31:0] pc;
      logic        dchk;
   } vec_t;

   vec_t        tbl[$];
   int unsigned n_vec  = 0;
   int unsigned n_miss = 0;

   function automatic vec_t mk(input logic rst, input logic gnt, input logic rv,
                               input logic [31:0] rdata, input logic redir,
                               input logic [31:0] rpc, input logic ready,
                               input logic req, input logic [31:0] addr,
                               input logic valid, input logic [31:0] inst,
                               input logic [31:0] pc, input logic dchk);
      vec_t v;
      v.rst = rst;   v.gnt = gnt;     v.rv = rv;     v.rdata = rdata;
      v.redir = redir; v.rpc = rpc;   v.ready = ready;
      v.req = req;   v.addr = addr;   v.valid = valid;
      v.inst = inst; v.pc = pc;       v.dchk = dchk;
      return v;
   endfunction

   task automatic cmp(input string name, input int idx,
                      input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s[%0d]: got %h, expected %h", name, idx, act, exp);
      end
   endtask

   // Drive one cycle of inputs at the falling edge and check the outputs 1 ns later.
   task automatic apply(input bit sel_b, input vec_t v, input string tag, input int idx);
      logic        o_req, o_valid;
      logic [31:0] o_addr, o_inst, o_pc;
      @(negedge clk);
      if (sel_b) begin
         rst_b = v.rst; gnt_b = v.gnt; rv_b = v.rv; rdata_b = v.rdata;
         redir_b = v.redir; rpc_b = v.rpc; ready_b = v.ready;
      end else begin
         rst_a = v.rst; gnt_a = v.gnt; rv_a = v.rv; rdata_a = v.rdata;
         redir_a = v.redir; rpc_a = v.rpc; ready_a = v.ready;
      end
      #1;
      o_req   = sel_b ? req_b   : req_a;
      o_addr  = sel_b ? addr_b  : addr_a;
      o_valid = sel_b ? valid_b : valid_a;
      o_inst  = sel_b ? inst_b  : inst_a;
      o_pc    = sel_b ? pc_b    : pc_a;
      cmp({tag, ".req"},   idx, 32'(o_req),   32'(v.req));
      cmp({tag, ".addr"},  idx, o_addr,       v.addr);
      cmp({tag, ".valid"}, idx, 32'(o_valid), 32'(v.valid));
      if (v.valid || v.dchk) begin
         cmp({tag, ".inst"}, idx, o_inst, v.inst);
         cmp({tag, ".pc"},   idx, o_pc,   v.pc);
      end
   endtask

   initial begin
      rst_a = 1'b1; gnt_a = 1'b0; rv_a = 1'b0; rdata_a = '0; redir_a = 1'b0; rpc_a = '0; ready_a = 1'b0;
      rst_b = 1'b1; gnt_b = 1'b0; rv_b = 1'b0; rdata_b = '0; redir_b = 1'b0; rpc_b = '0; ready_b = 1'b0;

      //           rst gnt rv rdata      rdr rpc      rdy   req addr         vld inst       pc       dchk
      // reset, then backpressure with ready low (DEPTH=2)
      tbl.push_back(mk(1, 1, 0, 0,        0, 0,       0,    0, 32'h000,    0, 0,         0,       1));
      tbl.push_back(mk(1, 1, 0, 0,        0, 0,       0,    0, 32'h000,    0, 0,         0,       1));
      tbl.push_back(mk(0, 1, 0, 0,        0, 0,       0,    1, 32'h000,    0, 0,         0,       1));
      tbl.push_back(mk(0, 1, 1, A,        0, 0,       0,    1, 32'h004,    0, 0,         0,       1));
      tbl.push_back(mk(0, 1, 1, A|32'h4,  0, 0,       0,    0, 32'h008,    1, A,         32'h0,   0));
      tbl.push_back(mk(0, 1, 0, 0,        0, 0,       0,    0, 32'h008,    1, A,         32'h0,   0));
      tbl.push_back(mk(0, 1, 0, 0,        0, 0,       0,    0, 32'h008,    1, A,         32'h0,   0));
      // one-cycle ready pops PC 0, then grant stall at 0x8 for three cycles
      tbl.push_back(mk(0, 0, 0, 0,        0, 0,       1,    0, 32'h008,    1, A,         32'h0,   0));
      tbl.push_back(mk(0, 0, 0, 0,        0, 0,       0,    1, 32'h008,    1, A|32'h4,   32'h4,   0));
      tbl.push_back(mk(0, 0, 0, 0,        0, 0,       0,    1, 32'h008,    1, A|32'h4,   32'h4,   0));
      tbl.push_back(mk(0, 0, 0, 0,        0, 0,       0,    1, 32'h008,    1, A|32'h4,   32'h4,   0));
      tbl.push_back(mk(0, 1, 0, 0,        0, 0,       0,    1, 32'h008,    1, A|32'h4,   32'h4,   0));
      tbl.push_back(mk(0, 0, 1, A|32'h8,  0, 0,       0,    0, 32'h00C,    1, A|32'h4,   32'h4,   0));
      tbl.push_back(mk(0, 0, 0, 0,        0, 0,       1,    0, 32'h00C,    1, A|32'h4,   32'h4,   0));
      tbl.push_back(mk(0, 1, 0, 0,        0, 0,       1,    1, 32'h00C,    1, A|32'h8,   32'h8,   0));
      // two requests in flight (0xC, 0x10), redirect to 0x103
      tbl.push_back(mk(0, 1, 0, 0,        0, 0,       1,    1, 32'h010,    0, 0,         0,       0));
      tbl.push_back(mk(0, 1, 0, 0,        1, 32'h103, 1,    0, 32'h014,    0, 0,         0,       0));
      tbl.push_back(mk(0, 1, 1, A|32'hC,  0, 0,       1,    0, 32'h100,    0, 0,         0,       0));
      tbl.push_back(mk(0, 1, 1, A|32'h10, 0, 0,       1,    1, 32'h100,    0, 0,         0,       0));
      tbl.push_back(mk(0, 1, 1, A|32'h100,0, 0,       1,    1, 32'h104,    0, 0,         0,       0));
      tbl.push_back(mk(0, 1, 1, A|32'h104,0, 0,       0,    0, 32'h108,    1, A|32'h100, 32'h100, 0));
      tbl.push_back(mk(0, 0, 0, 0,        0, 0,       1,    0, 32'h108,    1, A|32'h100, 32'h100, 0));
      tbl.push_back(mk(0, 0, 0, 0,        0, 0,       1,    1, 32'h108,    1, A|32'h104, 32'h104, 0));
      tbl.push_back(mk(0, 0, 0, 0,        0, 0,       1,    1, 32'h108,    0, 0,         0,       0));

      foreach (tbl[i]) apply(1'b0, tbl[i], "tbl", i);

      // Streaming on DEPTH=4: one grant and one delivered instruction per cycle.
      begin
         logic        prev_gnt;
         logic [31:0] prev_addr, exp_addr, exp_pc;
         prev_gnt  = 1'b0;
         prev_addr = '0;
         for (int c = 0; c < 10; c++) begin
            exp_addr = 32'h200 + 32'(4 * c);
            exp_pc   = 32'h200 + 32'(4 * (c - 2));
            if (c >= 2)
               apply(1'b1, mk(0, 1, prev_gnt, A | prev_addr, 0, 0, 1,
                              1, exp_addr, 1, A | exp_pc, exp_pc, 0), "stream", c);
            else
               apply(1'b1, mk(0, 1, prev_gnt, A | prev_addr, 0, 0, 1,
                              1, exp_addr, 0, 0, 0, 1), "stream", c);
            prev_gnt  = 1'b1;
            prev_addr = exp_addr;
         end
      end

      // pend=2, count=1: redirect, response and pop handshake in one cycle.
      apply(1'b1, mk(0, 1, 0, 0,        0, 0,       0, 1, 32'h228, 1, A|32'h220, 32'h220, 0), "simul", 0);
      apply(1'b1, mk(0, 1, 1, A|32'h224,1, 32'h302, 1, 0, 32'h22C, 1, A|32'h220, 32'h220, 0), "simul", 1);
      apply(1'b1, mk(0, 0, 1, A|32'h228,0, 0,       1, 1, 32'h300, 0, 0,         0,       0), "simul", 2);
      apply(1'b1, mk(0, 1, 0, 0,        0, 0,       1, 1, 32'h300, 0, 0,         0,       0), "simul", 3);
      apply(1'b1, mk(0, 0, 1, A|32'h300,0, 0,       0, 1, 32'h304, 0, 0,         0,       0), "simul", 4);
      apply(1'b1, mk(0, 0, 0, 0,        0, 0,       0, 1, 32'h304, 1, A|32'h300, 32'h300, 0), "simul", 5);

      // Back-to-back redirects: the second recomputes drop from the current pend.
      apply(1'b1, mk(0, 1, 0, 0,        0, 0,       0, 1, 32'h304, 1, A|32'h300, 32'h300, 0), "b2b", 0);
      apply(1'b1, mk(0, 1, 0, 0,        1, 32'h400, 0, 0, 32'h308, 1, A|32'h300, 32'h300, 0), "b2b", 1);
      apply(1'b1, mk(0, 1, 1, A|32'h304,1, 32'h500, 0, 0, 32'h400, 0, 0,         0,       0), "b2b", 2);
      apply(1'b1, mk(0, 1, 0, 0,        0, 0,       1, 1, 32'h500, 0, 0,         0,       0), "b2b", 3);
      apply(1'b1, mk(0, 0, 1, A|32'h500,0, 0,       1, 1, 32'h504, 0, 0,         0,       0), "b2b", 4);
      apply(1'b1, mk(0, 0, 0, 0,        0, 0,       0, 1, 32'h504, 1, A|32'h500, 32'h500, 0), "b2b", 5);

      // Asynchronous reset pulse between clock edges while the FIFO holds data.
      @(negedge clk);
      gnt_b = 1'b0; rv_b = 1'b0; ready_b = 1'b0; redir_b = 1'b0;
      #1;
      cmp("arst.pre_valid", 0, 32'(valid_b), 32'd1);
      #1 rst_b = 1'b1;
      #1;
      cmp("arst.valid", 0, 32'(valid_b), 32'd0);
      cmp("arst.req",   0, 32'(req_b),   32'd0);
      cmp("arst.inst",  0, inst_b,       32'h0);
      cmp("arst.pc",    0, pc_b,         32'h0);
      cmp("arst.addr",  0, addr_b,       32'h200);
      #1 rst_b = 1'b0;
      apply(1'b1, mk(0, 1, 0, 0,        0, 0,       1, 1, 32'h200, 0, 0,         0,       1), "arst", 1);
      apply(1'b1, mk(0, 0, 1, A|32'h200,0, 0,       1, 1, 32'h204, 0, 0,         0,       1), "arst", 2);
      apply(1'b1, mk(0, 0, 0, 0,        0, 0,       1, 1, 32'h204, 1, A|32'h200, 32'h200, 0), "arst", 3);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
